sal_ref_ctrl: RTL and testbench
===============================

Name: sal_ref_ctrl

Overview:
- All-bank refresh scheduler for the DDR controller.
- Generates the per-bank `ref_req` inputs of the bank controllers, which are currently tied off, and collects their `ref_gnt` responses.
- Counts tREFI, accumulates postponed refresh credits, blocks all banks for tRFC, and pulses a refresh-command strobe to the command scheduler/encoder path.
- Sits beside the configuration block, upstream of the bank controllers.

Parameters:
- BK_CNT, 4, number of bank controllers served.
- TREFI_W, 16, width of the tREFI interval counter.
- TRFC_W, 8, width of the tRFC counter.
- POSTPONE_MAX, 8, maximum accumulated refresh credits (JEDEC postpone limit).
- URGENT_TH, 6, credit count at or above which urgency is flagged.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous, active-high reset.
- ref_en_i  in  1  refresh enable from configuration.
- cfg_trefi_i  in  TREFI_W  refresh interval in cycles; 0 = no credit generation.
- cfg_trfc_i  in  TRFC_W  refresh cycle time in cycles; 0 treated as 1.
- ref_gnt_i  in  BK_CNT  per-bank grant: bank precharged and quiescent.
- ref_req_o  out  BK_CNT  per-bank refresh request, all bits identical.
- ref_cmd_o  out  1  one-cycle REF command strobe.
- ref_busy_o  out  1  high in REQ or RFC state.
- ref_urgent_o  out  1  pending credits >= URGENT_TH.
- pending_o  out  4  current credit count.
- overflow_o  out  1  sticky: a tick arrived while credits = POSTPONE_MAX.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM=IDLE, pending=0, grant mask=0, overflow=0.
  - Interval counter loaded with cfg_trefi_i.
  - All outputs 0.
  - Reset mid-refresh aborts immediately; no ref_cmd_o is emitted.
- Interval counter:
  - Decrements each cycle while ref_en_i=1 and cfg_trefi_i!=0.
  - When the counter equals 1, it reloads cfg_trefi_i and produces a one-cycle tick. With cfg_trefi_i=N, the first tick is N cycles after reset deassert, then every N cycles.
  - Holds its value while ref_en_i=0.
  - A cfg_trefi_i change takes effect at the next reload.
- Credits:
  - A tick increments pending, saturating at POSTPONE_MAX.
  - A tick at saturation sets overflow_o; it is cleared only by rst.
  - Refresh completion decrements pending.
  - Tick and completion in the same cycle: pending is unchanged.
- FSM:
  - IDLE:
    - If pending>0 and ref_en_i=1, go to REQ.
    - Grant mask is cleared on entry.
  - REQ:
    - ref_req_o all ones.
    - Grant mask bit i is set when ref_gnt_i[i]=1. Grants are sticky, so a grant that later drops still counts.
    - Grants outside REQ/RFC are ignored.
    - When (mask | ref_gnt_i) is all ones, go to RFC. ref_cmd_o=1 in the first RFC cycle.
    - The RFC counter is loaded with max(cfg_trfc_i,1).
  - RFC:
    - ref_req_o stays all ones.
    - Counter decrements each cycle; at 1, the completion pulse fires and the FSM goes to IDLE.
    - ref_req_o drops in the IDLE cycle.
    - Occupancy is exactly max(cfg_trfc_i,1) cycles.
- Back-to-back refreshes: with pending still >0 after completion, IDLE lasts exactly one cycle, then REQ again.
- ref_en_i deasserted in REQ or RFC: the current refresh completes normally. The FSM then stays in IDLE with pending held.
- ref_urgent_o and pending_o are registered and reflect the post-update count of the same edge.
- Latency: ref_req_o asserts 1 cycle after pending becomes nonzero (IDLE→REQ). Minimum tick-to-ref_cmd_o latency is 2 cycles when all grants are already high.
- Arithmetic: all counters are unsigned. pending width is 4 bits, so POSTPONE_MAX<=15 is checked by an elaboration-time assertion.

Test Plan:
- Basic refresh:
  - Stimulus: rst then release, ref_en=1, trefi=100, trfc=10, ref_gnt_i tied high.
  - Required response: tick at cycle 100, ref_req_o=4'hF from cycle 101, ref_cmd_o single pulse at 102, ref_req_o low at 112, pending back to 0.
- Staggered grants:
  - Stimulus: banks grant at +3, +7 (bank 0 drops after 1 cycle), +12, +20 relative to the REQ state.
  - Required response: ref_cmd_o only after the cycle-20 grant, exactly once.
- Postpone and saturate:
  - Stimulus: trefi=10, ref_gnt_i=0 for 120 cycles.
  - Required response:
    - pending reaches 8.
    - ref_urgent_o high from pending=6.
    - overflow_o sets on the 9th tick and stays set.
    - After grants are raised, 8 back-to-back refreshes complete with 1 IDLE cycle between each.
- Simultaneous tick and completion:
  - Stimulus: trefi and trfc chosen so a tick lands on the completion cycle with pending=2.
  - Required response: pending stays 2 on that edge, next refresh starts.
- Disable mid-RFC:
  - Stimulus: drop ref_en in the 3rd RFC cycle with pending=3.
  - Required response: the current refresh ends after trfc cycles, pending=2, no further ref_req_o, interval counter frozen. Re-enable resumes refreshes.
- Reset mid-REQ, and trfc=0:
  - Stimulus: assert rst during REQ.
  - Required response: next cycle all outputs 0 and pending 0, no ref_cmd_o.
  - Stimulus: run a refresh with cfg_trfc_i=0.
  - Required response: RFC lasts 1 cycle.

Source files
------------

// File: rtl/sal_ref_ctrl.sv
`default_nettype none
// ============================================================================
// sal_ref_ctrl : all-bank refresh scheduler (tREFI credits, tRFC bank block)
// Revision 1.0
// ============================================================================
module sal_ref_ctrl #(
   parameter int BK_CNT       = 4,
   parameter int TREFI_W      = 16,
   parameter int TRFC_W       = 8,
   parameter int POSTPONE_MAX = 8,
   parameter int URGENT_TH    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ref_en_i,
   input  logic [TREFI_W-1:0]  cfg_trefi_i,
   input  logic [TRFC_W-1:0]   cfg_trfc_i,
   input  logic [BK_CNT-1:0]   ref_gnt_i,
   output logic [BK_CNT-1:0]   ref_req_o,
   output logic                ref_cmd_o,
   output logic                ref_busy_o,
   output logic                ref_urgent_o,
   output logic [3:0]          pending_o,
   output logic                overflow_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_RFC   = 2'd2;
   localparam logic [3:0] PEND_MAX = 4'(POSTPONE_MAX);
   localparam logic [3:0] URG_TH   = 4'(URGENT_TH);

   generate
      if (POSTPONE_MAX > 15 || POSTPONE_MAX < 1) begin : g_bad_postpone
         $error("POSTPONE_MAX must fit the 4-bit credit counter");
      end
   endgenerate

   logic [1:0]         state;
   logic [TREFI_W-1:0] intv_cnt;
   logic [TRFC_W-1:0]  rfc_cnt;
   logic [TRFC_W-1:0]  trfc_eff;
   logic [BK_CNT-1:0]  gnt_mask;
   logic [3:0]         pending;
   logic [3:0]         pending_nxt;
   logic               cnt_run;
   logic               tick;
   logic               done;
   logic               all_gnt;
   logic               cmd_pulse;
   logic               urgent;
   logic               overflow;

   assign cnt_run  = ref_en_i && (cfg_trefi_i != '0);
   assign tick     = cnt_run && (intv_cnt == TREFI_W'(1));
   assign done     = (state == ST_RFC) && (rfc_cnt == TRFC_W'(1));
   assign all_gnt  = &(gnt_mask | ref_gnt_i);
   assign trfc_eff = (cfg_trfc_i == '0) ? TRFC_W'(1) : cfg_trfc_i;

   // A zero count (left over from cfg_trefi_i=0) reloads without a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         intv_cnt <= cfg_trefi_i;
      end else if (cnt_run) begin
         if (intv_cnt <= TREFI_W'(1)) begin
            intv_cnt <= cfg_trefi_i;
         end else begin
            intv_cnt <= intv_cnt - TREFI_W'(1);
         end
      end
   end

   always_comb begin
      pending_nxt = pending;
      if (tick && !done) begin
         if (pending != PEND_MAX) begin
            pending_nxt = pending + 4'd1;
         end
      end else if (done && !tick) begin
         pending_nxt = pending - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= 4'd0;
         urgent   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         pending <= pending_nxt;
         urgent  <= (pending_nxt >= URG_TH);
         if (tick && (pending == PEND_MAX)) begin
            overflow <= 1'b1;
         end
      end
   end

   // Grants are accumulated so a bank that drops its grant still counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt_mask  <= '0;
         rfc_cnt   <= '0;
         cmd_pulse <= 1'b0;
      end else begin
         cmd_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               gnt_mask <= '0;
               if ((pending != 4'd0) && ref_en_i) begin
                  state <= ST_REQ;
               end
            end
            ST_REQ: begin
               gnt_mask <= gnt_mask | ref_gnt_i;
               if (all_gnt) begin
                  state     <= ST_RFC;
                  rfc_cnt   <= trfc_eff;
                  cmd_pulse <= 1'b1;
               end
            end
            ST_RFC: begin
               if (done) begin
                  state <= ST_IDLE;
               end else begin
                  rfc_cnt <= rfc_cnt - TRFC_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ref_req_o    = {BK_CNT{state != ST_IDLE}};
   assign ref_busy_o   = (state != ST_IDLE);
   assign ref_cmd_o    = cmd_pulse;
   assign ref_urgent_o = urgent;
   assign pending_o    = pending;
   assign overflow_o   = overflow;

endmodule
`default_nettype wire

// File: tb/tb_sal_ref_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sal_ref_ctrl : directed bench with a timestamp-based refresh model
// Revision 1.0
// ============================================================================
module tb_sal_ref_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ref_en = 1'b0;
   logic [15:0] trefi = 16'd100;
   logic [7:0]  trfc = 8'd10;
   logic [3:0]  gnt = 4'h0;
   logic [3:0]  ref_req;
   logic        ref_cmd;
   logic        ref_busy;
   logic        ref_urgent;
   logic [3:0]  pending;
   logic        overflow;

   sal_ref_ctrl #(
      .BK_CNT(4), .TREFI_W(16), .TRFC_W(8), .POSTPONE_MAX(8), .URGENT_TH(6)
   ) dut (
      .clk(clk), .rst(rst), .ref_en_i(ref_en), .cfg_trefi_i(trefi),
      .cfg_trfc_i(trfc), .ref_gnt_i(gnt), .ref_req_o(ref_req),
      .ref_cmd_o(ref_cmd), .ref_busy_o(ref_busy), .ref_urgent_o(ref_urgent),
      .pending_o(pending), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cmd_seen = 0;

   // Model state: cycle number since reset, credits, and refresh phase
   // (0 idle, 1 waiting for grants, 2 busy until edge m_rfc_end).
   int         cyc = 0;
   bit         live = 0;
   int         m_pend, m_per, m_elap, m_ph, m_rfc_end;
   bit         m_ovf, m_cmd;
   logic [3:0] m_mask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      bit tick, done;
      int len;
      if (rst) begin
         live = 1; cyc = 0; m_pend = 0; m_ovf = 0; m_per = int'(trefi); m_elap = 0;
         m_ph = 0; m_mask = 4'h0; m_cmd = 0; m_rfc_end = 0;
         return;
      end
      cyc++;
      tick = 0;
      done = 0;
      if (ref_en && trefi != 0) begin
         if (m_per == 0) begin
            m_per = int'(trefi); m_elap = 0;
         end else if (m_elap + 1 >= m_per) begin
            tick = 1; m_per = int'(trefi); m_elap = 0;
         end else begin
            m_elap++;
         end
      end
      m_cmd = 0;
      case (m_ph)
         0: begin
            m_mask = 4'h0;
            if (m_pend > 0 && ref_en) m_ph = 1;
         end
         1: begin
            m_mask = m_mask | gnt;
            if (m_mask == 4'hF) begin
               len = (trfc == 0) ? 1 : int'(trfc);
               m_ph = 2; m_cmd = 1; m_rfc_end = cyc + len;
            end
         end
         default: begin
            if (cyc == m_rfc_end) begin
               done = 1; m_ph = 0;
            end
         end
      endcase
      if (tick && m_pend == 8) m_ovf = 1;
      m_pend = m_pend + (tick ? 1 : 0) - (done ? 1 : 0);
      if (m_pend > 8) m_pend = 8;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (live) begin
            chk("m_req", ref_req, (m_ph != 0) ? 4'hF : 4'h0);
            chk("m_cmd", ref_cmd, m_cmd);
            chk("m_busy", ref_busy, m_ph != 0);
            chk("m_urgent", ref_urgent, m_pend >= 6);
            chk("m_pending", pending, m_pend);
            chk("m_overflow", overflow, m_ovf);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ref_cmd === 1'b1) cmd_seen++;
      end
   end

   task automatic goto(input int c);
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc != c && guard < 3000);
      if (cyc != c) begin
         n_checks++; n_fail++;
         $display("FAIL goto: reached cycle %0d, wanted %0d", cyc, c);
      end
   endtask

   task automatic do_reset(input logic [15:0] t_refi, input logic [7:0] t_rfc, input logic [3:0] g);
      @(negedge clk);
      rst = 1'b1; ref_en = 1'b1; trefi = t_refi; trfc = t_rfc; gnt = g;
      @(negedge clk);
      rst = 1'b0;
   endtask

   int s0;

   initial begin
      // Basic refresh
      do_reset(16'd100, 8'd10, 4'hF);
      chk("t1_reset_pend", pending, 0);
      chk("t1_reset_req", ref_req, 4'h0);
      goto(99);  chk("t1_pend99", pending, 0);
      goto(100); chk("t1_pend100", pending, 1); chk("t1_req100", ref_req, 4'h0);
      goto(101); chk("t1_req101", ref_req, 4'hF); chk("t1_cmd101", ref_cmd, 0);
      goto(102); chk("t1_cmd102", ref_cmd, 1);
      goto(103); chk("t1_cmd103", ref_cmd, 0);
      goto(111); chk("t1_req111", ref_req, 4'hF);
      goto(112); chk("t1_req112", ref_req, 4'h0); chk("t1_pend112", pending, 0);

      // Staggered grants
      do_reset(16'd100, 8'd10, 4'h0);
      goto(100); s0 = cmd_seen;
      goto(104); gnt = 4'b0001;
      goto(105); gnt = 4'b0000;
      goto(108); gnt = 4'b0010;
      goto(113); gnt = 4'b0110;
      goto(121); chk("t2_cmd121", ref_cmd, 0); gnt = 4'b1110;
      goto(122); chk("t2_cmd122", ref_cmd, 1);
      goto(140); chk("t2_cmd_count", cmd_seen - s0, 1);

      // Postpone and saturate
      do_reset(16'd10, 8'd4, 4'h0);
      goto(59);  chk("t3_pend59", pending, 5); chk("t3_urg59", ref_urgent, 0);
      goto(60);  chk("t3_pend60", pending, 6); chk("t3_urg60", ref_urgent, 1);
      goto(80);  chk("t3_pend80", pending, 8);
      goto(89);  chk("t3_ovf89", overflow, 0);
      goto(90);  chk("t3_ovf90", overflow, 1); chk("t3_pend90", pending, 8);
      goto(115); trefi = 16'd1000;
      goto(120); chk("t3_pend120", pending, 8); s0 = cmd_seen; gnt = 4'hF;
      goto(121); chk("t3_cmd121", ref_cmd, 1);
      goto(125); chk("t3_req125", ref_req, 4'h0); chk("t3_pend125", pending, 7);
      goto(126); chk("t3_req126", ref_req, 4'hF);
      goto(127); chk("t3_cmd127", ref_cmd, 1);
      goto(167); chk("t3_pend167", pending, 0); chk("t3_ovf167", overflow, 1);
      goto(180); chk("t3_cmd_count", cmd_seen - s0, 8);

      // Tick coinciding with completion
      do_reset(16'd10, 8'd9, 4'h0);
      goto(20); chk("t4_pend20", pending, 2); gnt = 4'hF;
      goto(29); chk("t4_pend29", pending, 2); chk("t4_busy29", ref_busy, 1);
      goto(30); chk("t4_pend30", pending, 2); chk("t4_req30", ref_req, 4'h0);
      goto(31); chk("t4_req31", ref_req, 4'hF);
      goto(32); chk("t4_cmd32", ref_cmd, 1);

      // Disable mid-RFC
      do_reset(16'd10, 8'd10, 4'h0);
      goto(30); chk("t5_pend30", pending, 3); gnt = 4'hF;
      goto(33); ref_en = 1'b0;
      goto(40); chk("t5_busy40", ref_busy, 1);
      goto(41); chk("t5_pend41", pending, 2); chk("t5_req41", ref_req, 4'h0);
      goto(60); chk("t5_req60", ref_req, 4'h0); chk("t5_pend60", pending, 2); ref_en = 1'b1;
      goto(61); chk("t5_req61", ref_req, 4'hF);
      goto(62); chk("t5_cmd62", ref_cmd, 1);
      goto(66); chk("t5_pend66", pending, 2);
      goto(67); chk("t5_pend67", pending, 3);

      // Reset during REQ
      do_reset(16'd10, 8'd5, 4'h0);
      goto(13); chk("t6_req13", ref_req, 4'hF);
      s0 = cmd_seen; rst = 1'b1; gnt = 4'hF;
      @(negedge clk);
      chk("t6_rst_req", ref_req, 4'h0); chk("t6_rst_cmd", ref_cmd, 0);
      chk("t6_rst_busy", ref_busy, 0); chk("t6_rst_pend", pending, 0);
      chk("t6_rst_urg", ref_urgent, 0); chk("t6_rst_ovf", overflow, 0);
      rst = 1'b0;
      goto(5); chk("t6_no_cmd", cmd_seen - s0, 0);

      // tRFC = 0 behaves as a single cycle
      do_reset(16'd10, 8'd0, 4'hF);
      goto(12); chk("t7_cmd12", ref_cmd, 1); chk("t7_busy12", ref_busy, 1);
      goto(13); chk("t7_busy13", ref_busy, 0); chk("t7_req13", ref_req, 4'h0);
      chk("t7_pend13", pending, 0);

      goto(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
